// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: multi-stage valid/ready pipeline register with synchronous
// flush and bubble collapsing.
//
// Optional feature macro: PIPE_REG_HS_SKID_EN
//   undefined : no skid entry, in_ready = rdy[0] (combinational from
//               out_ready), capacity STAGES.
//   defined   : one-entry skid buffer ahead of slot 0, in_ready driven
//               straight from a flop, capacity STAGES+1.
//
// Empty slots always hold a zero payload, so out_data reads 0 whenever
// out_valid is low after reset, flush or a bubble.

module pipe_reg_hs #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CW     = $clog2(STAGES + 2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Slot state: valid bits and payload, slot STAGES-1 faces the output.
  logic [STAGES-1:0]            v;
  logic [STAGES-1:0][WIDTH-1:0] d;

  // Per-slot advance enables and the source each slot would load from.
  logic [STAGES-1:0]            rdy;
  logic                         rdy_acc;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0][WIDTH-1:0] src_d;

  // Beat presented to slot 0 (input or skid entry).
  logic                         head_v;
  logic [WIDTH-1:0]             head_d;

  logic                         in_xfer;
  logic                         out_xfer;

  // Ready chain: a slot may advance if it or any slot downstream is empty,
  // or the output is accepting.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy_acc = rdy_acc | ~v[i];
      rdy[i]  = rdy_acc;
    end
  end

  // Source selection: slot 0 from the head beat, others from the slot before.
  always_comb begin
    src_v    = '0;
    src_d    = '0;
    src_v[0] = head_v;
    src_d[0] = head_d;
    for (int i = 1; i < int'(STAGES); i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

`ifdef PIPE_REG_HS_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;

  // in_ready comes straight from the skid flop, breaking the out_ready path.
  assign in_ready = ~skid_v;

  // Skid entry drains into slot 0 ahead of any new input.
  always_comb begin
    head_v = in_valid;
    head_d = in_data;
    if (skid_v) begin
      head_v = 1'b1;
      head_d = skid_d;
    end
  end

  // Skid entry: capture a beat accepted while slot 0 is stalled, release on advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (flush) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (skid_v) begin
      if (rdy[0]) begin
        skid_v <= 1'b0;
        skid_d <= '0;
      end
    end else if (in_valid && !rdy[0]) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end
`else
  // Without a skid entry the chain accepts exactly when slot 0 can advance.
  assign in_ready = rdy[0];

  // Slot 0 is fed directly from the input.
  always_comb begin
    head_v = in_valid;
    head_d = in_data;
  end
`endif

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v[STAGES-1] & out_ready;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Slot chain: flush clears everything, otherwise advancing slots load their
  // source and stalled slots hold bit-exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      d <= '0;
    end else if (flush) begin
      v <= '0;
      d <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (rdy[i]) begin
          v[i] <= src_v[i];
          d[i] <= src_v[i] ? src_d[i] : '0;
        end
      end
    end
  end

  // Occupancy counter: +1 per input transfer, -1 per output transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/pipe_reg_hs.md
# pipe_reg_hs

Parametrised multi-stage pipeline register with a valid/ready handshake, synchronous flush and bubble collapsing. It is the successor to the single enable/clear flop used between datapath stages. It carries a WIDTH-bit payload through STAGES register slots, holds data under back-pressure and zeroes payload on flush. It sits between pipeline stages of the RISC-V core and in front of the memory-side interfaces, wherever a stall/flush-capable register chain is needed.

## Interface
- WIDTH, 32, payload width in bits (>=1)
- STAGES, 2, number of register slots in the chain (>=1)
- CW, $clog2(STAGES+2), width of `count` (derived; not to be overridden)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of every slot (and skid entry)
- in_valid  in  1  upstream beat present
- in_ready  out  1  chain can accept a beat this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  last slot holds a beat
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  payload of last slot
- count  out  CW  number of beats held (slots + skid entry)

## Operation
- Slot i holds v[i] and d[i]. Slot 0 is fed from the input; slot STAGES-1 drives out_valid/out_data.
- Per-slot advance: rdy[STAGES-1] = ~v[STAGES-1] | out_ready; rdy[i] = ~v[i] | rdy[i+1].
- When rdy[i] is 1, slot i loads from slot i-1, or from the input for i=0. Slot i takes valid from its source and clears when the source is invalid, so bubbles collapse.
- When rdy[i] is 0, slot i holds. Data is held bit-exact while stalled.
- The input transfers when in_valid & in_ready. The output transfers when out_valid & out_ready.
- flush: on the edge where flush=1, every v[i] is set to 0 and every d[i] is set to 0 (the same for the skid entry).
  - A beat accepted at the input in that cycle is dropped.
  - A beat transferred at the output in that cycle counts as delivered.
  - flush has priority over all other updates.
- count is the registered number of valid entries. It updates every edge: +1 per input transfer, -1 per output transfer, 0 on flush.
- Payload is never reordered, duplicated or lost except by flush.

## Timing
- Reset (reset_n=0, asynchronous): all v=0, all d=0, skid empty, count=0, out_valid=0, out_data=0. in_ready is 1 once reset_n is deasserted.
- Deassertion of reset_n takes effect at the next rising edge.
- Reset mid-stream discards all beats immediately, without waiting for a clock edge.
- Latency with no back-pressure: a beat accepted at edge k has out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles of register delay.
- Throughput is 1 beat/cycle with out_ready held high.
- A full chain with out_ready=1 accepts and delivers in the same cycle.
- Without skid, in_ready is combinational from out_ready (path depth STAGES).
- flush and out_ready/in_valid together in one cycle: after the edge, count=0 and out_valid=0.

## Configuration
- Macro: PIPE_REG_HS_SKID_EN.
- Defined:
  - A 1-entry skid buffer sits in front of slot 0, and in_ready = ~skid_valid is driven purely from a flop, with no combinational path from out_ready.
  - A beat accepted while rdy[0]=0 goes to the skid entry. The skid entry drains into slot 0 with priority over the input when rdy[0]=1.
  - Capacity is STAGES+1.
  - Latency is unchanged when the skid entry is empty; it is +1 cycle for the beat that is skidded.
- Undefined:
  - No skid entry; in_ready = rdy[0] (combinational); capacity is STAGES.
  - count never exceeds STAGES.

## Test plan
- Reset: hold reset_n=0 mid-transfer with 2 beats in flight -> out_valid=0, out_data=0, count=0 without any clock edge.
- Streaming: STAGES=3, out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, first beat 3 cycles after accept, one beat per cycle.
- Back-pressure: fill the chain with out_ready=0 -> count=STAGES (STAGES+1 with the macro) and in_ready=0. Then set out_ready=1 for 1 cycle -> exactly one beat out, and in_ready=1 in the same cycle (without skid) or the next cycle (with skid).
- Bubble collapse: send 0xA, idle 2 cycles, send 0xB, out_ready=0 -> both beats pack into the last two slots, with 0xA at the output.
- Flush: chain holding 0xA,0xB with in_valid=1, in_data=0xC, flush=1 -> next cycle count=0, out_valid=0, out_data=0, and 0xC is never output.
- Simultaneous flush and output transfer: out_ready=1 with flush=1 -> the bench records 0xA delivered and nothing after it.
